// File: rtl/fetch_target_queue.sv
// Fetch target queue: holds predicted fetch-block addresses, issues them to the
// ICache in order and keeps them until IFU commit so misses/redirects can replay.
module fetch_target_queue #(
  parameter  int DEPTH = 8,
  parameter  int VLEN  = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             replay_i,
  input  logic             enq_valid_i,
  input  logic [VLEN-1:0]  enq_vaddr_i,
  output logic             enq_ready_o,
  output logic             icache_req_valid_o,
  output logic [VLEN-1:0]  icache_req_vaddr_o,
  input  logic             icache_ready_i,
  input  logic             commit_i,
  output logic [PTR_W:0]   count_o,
  output logic [PTR_W:0]   inflight_o
);

  localparam logic [PTR_W:0] PtrOne  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] PtrFull = (PTR_W+1)'(DEPTH);

  logic [VLEN-1:0] mem [DEPTH];

  logic [PTR_W:0] enq_ptr_q, enq_ptr_d;
  logic [PTR_W:0] iss_ptr_q, iss_ptr_d;
  logic [PTR_W:0] cmt_ptr_q, cmt_ptr_d;

  logic enq_fire;
  logic iss_fire;
  logic cmt_fire;

  // Pointers carry an extra wrap bit, so plain subtraction yields occupancy.
  assign count_o    = enq_ptr_q - cmt_ptr_q;
  assign inflight_o = iss_ptr_q - cmt_ptr_q;

  assign enq_ready_o        = (count_o != PtrFull);
  assign icache_req_valid_o = (iss_ptr_q != enq_ptr_q) && !flush_i && !replay_i;
  assign icache_req_vaddr_o = icache_req_valid_o ? mem[iss_ptr_q[PTR_W-1:0]] : '0;

  assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
  assign iss_fire = icache_req_valid_o && icache_ready_i;
  assign cmt_fire = commit_i && (cmt_ptr_q != iss_ptr_q) && !flush_i;

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    iss_ptr_d = iss_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    if (flush_i) begin
      enq_ptr_d = '0;
      iss_ptr_d = '0;
      cmt_ptr_d = '0;
    end else begin
      if (enq_fire) enq_ptr_d = enq_ptr_q + PtrOne;
      if (cmt_fire) cmt_ptr_d = cmt_ptr_q + PtrOne;
      // Replay rewinds to the oldest entry still uncommitted after this cycle's commit.
      if (replay_i)      iss_ptr_d = cmt_ptr_d;
      else if (iss_fire) iss_ptr_d = iss_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enq_ptr_q <= '0;
      iss_ptr_q <= '0;
      cmt_ptr_q <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      iss_ptr_q <= iss_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) mem[enq_ptr_q[PTR_W-1:0]] <= enq_vaddr_i;
  end

endmodule

// File: doc/fetch_target_queue.md
Name: fetch_target_queue

Overview:
- Circular queue of fetch-block start addresses between the branch predictor and the ICache.
- Issues one request per cycle on the FTQ->ICache channel (ftq2icache_req_t / icache2ftq_rsp_t fields).
- Holds each entry after issue until the IFU commits it, so an ICache miss or redirect can replay from the oldest uncommitted entry.
- Generalises the single-request FTQ channel with parametrised depth and address width, plus replay and flush modes.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2
- VLEN, 32, virtual address width (Cfg.VLEN)
- PTR_W, $clog2(DEPTH), index width; derived, not overridable

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  frontend redirect; discards all entries
- replay_i  in  1  rewind issue pointer to the oldest uncommitted entry
- enq_valid_i  in  1  predictor offers a fetch target
- enq_vaddr_i  in  VLEN  fetch target address
- enq_ready_o  out  1  queue can accept a target
- icache_req_valid_o  out  1  ftq2icache_req_t.valid
- icache_req_vaddr_o  out  VLEN  ftq2icache_req_t.vaddr
- icache_ready_i  in  1  icache2ftq_rsp_t.ready
- commit_i  in  1  IFU retires the oldest issued entry
- count_o  out  PTR_W+1  occupied entries (enqueued, not committed)
- inflight_o  out  PTR_W+1  issued, not committed

Behaviour:
- State: storage array mem[DEPTH] of VLEN bits; three PTR_W+1 pointers (index plus wrap bit): enq_ptr, iss_ptr, cmt_ptr. Invariant: cmt_ptr <= iss_ptr <= enq_ptr (modular).
- Reset (rst_ni low, asynchronous):
  - All pointers go to 0.
  - enq_ready_o=1, icache_req_valid_o=0, icache_req_vaddr_o=0, count_o=0, inflight_o=0.
  - mem is not reset.
- Derived values:
  - count = enq_ptr - cmt_ptr; full when count == DEPTH.
  - enq_ready_o = !full. It does not depend on same-cycle commit; no combinational path from commit_i.
- Enqueue: on enq_valid_i && enq_ready_o && !flush_i, write mem[enq_ptr.idx] and increment enq_ptr; the wrap bit toggles when the index passes DEPTH-1.
- Issue:
  - icache_req_valid_o = (iss_ptr != enq_ptr) && !flush_i && !replay_i.
  - icache_req_vaddr_o = mem[iss_ptr.idx] when valid, else 0.
  - On icache_req_valid_o && icache_ready_i, iss_ptr increments.
  - Once valid is asserted, vaddr is held stable until the handshake completes, unless flush or replay intervenes.
- Enqueue-to-issue latency: an entry written in cycle N can be issued no earlier than cycle N+1; there is no bypass.
- Commit:
  - On commit_i with cmt_ptr != iss_ptr, cmt_ptr increments and frees the slot.
  - commit_i with inflight == 0 is ignored; the state is unchanged.
- Replay:
  - Order within the cycle: a valid commit is applied first, then iss_ptr <= the new cmt_ptr.
  - Any issue handshake in the same cycle is discarded; valid is already low in a replay cycle.
  - An enqueue in the same cycle is accepted.
- Flush:
  - Highest priority: enq_ptr, iss_ptr and cmt_ptr all go to 0 next cycle.
  - Same-cycle enqueue, issue and commit are dropped.
  - enq_ready_o stays as computed; an accepted-looking handshake during flush is dropped by definition.
- Priority: flush > replay > normal operation.
- Simultaneous enqueue and commit while full: enq_ready_o is already 0, so the enqueue stalls; the freed slot is visible the next cycle.
- Pointer wrap is exercised by the 1-bit extension; full and empty are distinguished by the wrap bit.
- count_o = enq_ptr - cmt_ptr and inflight_o = iss_ptr - cmt_ptr, both registered-state derived.

Test Plan:
- Reset then idle:
  - After rst_ni deassert: enq_ready_o=1, icache_req_valid_o=0, count_o=0, vaddr=0.
  - Assert rst_ni low mid-traffic with count=5: all outputs return to reset values immediately.
- Fill/drain, DEPTH=8, icache_ready_i held 0:
  - Enqueue 0x1000..0x1038 (step 8) over 8 cycles: after the 8th, enq_ready_o=0 and count_o=8.
  - Release ready: requests appear in order 0x1000..0x1038, one per cycle; inflight_o counts up to 8.
- Wrap-around:
  - Run 20 enqueue/issue/commit sequences with commit one cycle after issue: vaddrs stay in order across pointer wrap.
  - count_o never exceeds 2.
- Replay:
  - Issue A, B, C (0x2000, 0x2010, 0x2020); commit A and pulse replay_i in the same cycle.
  - Next cycle: icache_req_vaddr_o=0x2010 with valid, and B, C are reissued.
- Flush:
  - With count_o=6, assert flush_i together with enq_valid_i (0x3000) and commit_i.
  - Next cycle: count_o=0, inflight_o=0, icache_req_valid_o=0; 0x3000 is not stored.
- Illegal commit: commit_i with inflight_o=0 and count_o=3 leaves count_o=3 and the pointers unchanged.
